mbe_mult_arbiter: RTL
=====================

# mbe_mult_arbiter

Shares one combinational 24x24 MBE multiplier between two requesters, using round-robin arbitration and valid/ready handshakes on both the request and result sides. The block registers the granted operands and drives them onto the shared multiplier. It captures the 48-bit product into a per-requester result holding register. It sits between two data sources/sinks and a single multiplier instance, so the multiplier does not need to be duplicated.

## Interface
Parameters:
- AW, 24, operand width (signed two's complement; passed through uninterpreted)
- PW, 48, product width (= 2*AW)

Ports:
- CLK  in  1  clock, rising edge
- RST_n  in  1  reset; asynchronous, active-low
- req0_valid / req1_valid  in  1  requester 0/1 presents an operand pair
- req0_ready / req1_ready  out  1  block accepts the pair at this edge
- req0_a, req0_b / req1_a, req1_b  in  AW  operands
- res0_valid / res1_valid  out  1  product available for requester 0/1
- res0_ready / res1_ready  in  1  requester 0/1 consumes its product
- res0_p / res1_p  out  PW  product
- mult_a, mult_b  out  AW  operands to the shared multiplier
- mult_p  in  PW  product from the shared multiplier (combinational)
- idle  out  1  no operation in flight and no result pending

## Operation
- **Stage S1 registers:**
  - s1_valid, s1_tag (0/1), s1_a, s1_b.
  - mult_a = s1_a and mult_b = s1_b at all times.
  - s1_a/s1_b load only on an accept; otherwise they hold their value.
- **Result slot per requester:** resX_valid and resX_p registers.
- **Accept:** an accept for X occurs when reqX_valid & reqX_ready at a rising edge.
- **Slot check:** okX = !(s1_valid & s1_tag==X) & (!resX_valid | resX_ready). Each requester therefore has at most one operation in flight.
- **Ready logic:**
  - req0_ready = ok0 & (ptr==0 | !(req1_valid & ok1)).
  - req1_ready = ok1 & (ptr==1 | !(req0_valid & ok0)).
  - ready never depends on the requester's own valid.
  - At most one accept occurs per edge.
- **Pointer:** ptr is the round-robin priority pointer. After any accept for X, ptr <= ~X. With no accept, ptr holds.
- **S1 update each edge:**
  - s1_valid <= (any accept).
  - On an accept, s1_tag <= X and s1_a/s1_b <= reqX operands.
  - S1 never stalls. The okX check guarantees the destination slot is free when S1 drains.
- **Result slot update each edge, for X:**
  - If s1_valid & s1_tag==X: resX_valid <= 1 and resX_p <= mult_p.
  - Else if resX_ready: resX_valid <= 0.
  - Else the slot holds.
  - resX_p holds its value when the slot is not loaded.
- **Simultaneous drain and load:** a drain (resX_valid & resX_ready) and a load of the same slot in one edge results in the load. The old value is consumed and the new value is stored.
- **idle:** idle = !s1_valid & !res0_valid & !res1_valid.
- **Arithmetic:** the product is mult_p exactly as supplied. The block performs no truncation, sign handling or rounding.
- **Reset (asserted at any time, including mid-operation):**
  - Clears ptr to 0.
  - Clears s1_valid, s1_tag, s1_a, s1_b, res0/1_valid and res0/1_p to 0.
  - In-flight operations are discarded.
  - Outputs during reset: reqX_ready = (other requester idle-eligible rule with zero state), i.e. req0_ready=1; req1_ready=!req0_valid; mult_a=mult_b=0; resX_valid=0; resX_p=0; idle=1.

## Timing
- **Latency:**
  - Accept at edge E0.
  - Operands appear on mult_a/mult_b after E0.
  - The product is captured at E1.
  - resX_valid is high after E1, so latency is 2 edges.
- **Throughput:**
  - Combined: 1 operation/cycle when both requesters are active.
  - Per requester: 1 operation every 2 cycles. A back-to-back accept for the same X is blocked while its operation is in S1.
- **Back-pressure:** resX_ready=0 with resX_valid=1 holds reqX_ready at 0 from the next decision onward. The other requester is unaffected.
- **Combinational paths:**
  - resX_ready → reqX_ready.
  - reqY_valid → reqX_ready.
  - The multiplier is combinational between mult_a/b and mult_p within one cycle.

## Test plan
- **Reset values:** assert RST_n=0 mid-stream → all resX_valid=0, mult_a=mult_b=0, idle=1, ptr=0. After release, the first simultaneous request is granted to requester 0.
- **Single operation:** req0 a=3, b=5 accepted at edge E0 → res0_valid=1 and res0_p=15 after E1. res0_ready=1 → res0_valid=0 after E2. idle returns to 1.
- **Fair arbitration:** both requesters valid continuously, both res_ready=1 → accepts alternate 0,1,0,1 on consecutive edges. Each resX_valid pulses every other cycle with the correct products.
- **Back-pressure:** res0_ready=0 while holding product 15 → req0_ready stays 0 for 5 cycles. Requester 1 keeps being accepted every 2 cycles. res0_p stays 15. Releasing res0_ready re-admits req0 within 1 cycle.
- **Signed values:**
  - a=0xFFFFFF, b=0x000002 → 0xFFFFFFFFFFFE.
  - a=0x800000, b=0x800000 → 0x400000000000.
  - Each value is checked against the multiplier output unchanged.
- **Reset mid-operation:** assert RST_n=0 one cycle after an accept → no resX_valid is ever raised for that operation. After release, req0_ready=1.

Source files
------------

// File: rtl/mbe_mult_arbiter.sv
// Round-robin front end that shares one external combinational AWxAW multiplier
// between two valid/ready requesters, with a one-deep result slot per requester.
module mbe_mult_arbiter #(
    parameter int AW = 24,
    parameter int PW = 48
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_a,
    input  logic [AW-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_a,
    input  logic [AW-1:0] req1_b,
    output logic          res0_valid,
    input  logic          res0_ready,
    output logic [PW-1:0] res0_p,
    output logic          res1_valid,
    input  logic          res1_ready,
    output logic [PW-1:0] res1_p,
    output logic [AW-1:0] mult_a,
    output logic [AW-1:0] mult_b,
    input  logic [PW-1:0] mult_p,
    output logic          idle
);

    logic          ptr;
    logic          s1_valid;
    logic          s1_tag;
    logic [AW-1:0] s1_a;
    logic [AW-1:0] s1_b;
    logic          ok0;
    logic          ok1;
    logic          acc0;
    logic          acc1;
    logic          load0;
    logic          load1;

    // A requester may issue only when nothing of its own is in S1 and its
    // result slot is empty or being drained this edge.
    assign ok0 = !(s1_valid && !s1_tag) && (!res0_valid || res0_ready);
    assign ok1 = !(s1_valid &&  s1_tag) && (!res1_valid || res1_ready);

    assign req0_ready = ok0 && (!ptr || !(req1_valid && ok1));
    assign req1_ready = ok1 && ( ptr || !(req0_valid && ok0));

    assign acc0  = req0_valid && req0_ready;
    assign acc1  = req1_valid && req1_ready;
    assign load0 = s1_valid && !s1_tag;
    assign load1 = s1_valid &&  s1_tag;

    assign mult_a = s1_a;
    assign mult_b = s1_b;
    assign idle   = !s1_valid && !res0_valid && !res1_valid;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ptr      <= 1'b0;
            s1_valid <= 1'b0;
            s1_tag   <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            s1_valid <= acc0 || acc1;
            if (acc0) begin
                ptr    <= 1'b1;
                s1_tag <= 1'b0;
                s1_a   <= req0_a;
                s1_b   <= req0_b;
            end else if (acc1) begin
                ptr    <= 1'b0;
                s1_tag <= 1'b1;
                s1_a   <= req1_a;
                s1_b   <= req1_b;
            end
        end
    end

    // A load wins over a simultaneous drain: the old product is consumed and
    // the new one takes its place.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            res0_valid <= 1'b0;
            res0_p     <= '0;
            res1_valid <= 1'b0;
            res1_p     <= '0;
        end else begin
            if (load0) begin
                res0_valid <= 1'b1;
                res0_p     <= mult_p;
            end else if (res0_ready) begin
                res0_valid <= 1'b0;
            end
            if (load1) begin
                res1_valid <= 1'b1;
                res1_p     <= mult_p;
            end else if (res1_ready) begin
                res1_valid <= 1'b0;
            end
        end
    end

endmodule
